// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with load, sync clear, combinational terminal count and sticky ovf.
// Define COUNTER_SATURATE_EN to hold at the terminal value instead of wrapping.
module mod_updown_counter #(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 64'sd1);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef COUNTER_SATURATE_EN
    localparam logic SATURATE_C = 1'b1;
`else
    localparam logic SATURATE_C = 1'b0;
`endif

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             tc_s;

    // Out-of-range load values clamp to the top of the sequence.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if ($unsigned(64'(v)) < $unsigned(64'(MODULUS))) begin
            r = v;
        end else begin
            r = MAX_C;
        end
        return r;
    endfunction

    // Terminal count: zero-latency so it can enable a cascaded stage.
    always_comb begin
        tc_s = 1'b0;
        if (en && !clr && !load) begin
            tc_s = (up_dn && (count_q == MAX_C)) || (!up_dn && (count_q == ZERO_C));
        end else begin
            tc_s = 1'b0;
        end
    end

    // Next-state: clr > load > en, one action per edge.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = ZERO_C;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = clamp_load(load_val);
            ovf_d   = 1'b0;
        end else if (en) begin
            if (tc_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
            if (up_dn) begin
                if (count_q == MAX_C) begin
                    count_d = SATURATE_C ? MAX_C : ZERO_C;
                end else begin
                    count_d = count_q + ONE_C;
                end
            end else begin
                if (count_q == ZERO_C) begin
                    count_d = SATURATE_C ? ZERO_C : MAX_C;
                end else begin
                    count_d = count_q - ONE_C;
                end
            end
        end else begin
            count_d = count_q;
            ovf_d   = ovf_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= ZERO_C;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;
    assign tc    = tc_s;

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter bit width; legal range 2..32.
REQ-002 Parameter MODULUS, default 16, count sequence length; legal range 2..2**WIDTH.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 clr  input  1  synchronous clear to zero, highest functional priority.
REQ-006 load  input  1  synchronous load of load_val.
REQ-007 load_val  input  WIDTH  value to load.
REQ-008 en  input  1  count enable.
REQ-009 up_dn  input  1  direction: 1 = count up, 0 = count down.
REQ-010 count  output  WIDTH  registered current count.
REQ-011 tc  output  1  combinational terminal-count indicator.
REQ-012 ovf  output  1  registered sticky wrap/saturate flag.

Function
REQ-013 Priority per cycle SHALL be clr > load > en; at most one action per edge.
REQ-014 clr=1: count <= 0 and ovf <= 0.
REQ-015 load=1, clr=0: count <= load_val if load_val < MODULUS, else MODULUS-1; ovf <= 0.
REQ-016 en=1, up_dn=1, no clr/load: count <= count+1; at count==MODULUS-1, count <= 0 (wrap).
REQ-017 en=1, up_dn=0, no clr/load: count <= count-1; at count==0, count <= MODULUS-1 (wrap).
REQ-018 en=0, no clr/load: count and ovf SHALL hold.
REQ-019 tc SHALL be 1 iff en=1, clr=0, load=0, and (up_dn=1 and count==MODULUS-1, or up_dn=0 and count==0); else 0.
REQ-020 tc SHALL be combinational from current count and inputs; zero latency, usable as en of a cascaded next stage.
REQ-021 ovf SHALL set to 1 on the edge where tc=1, and remain 1 until clr or load.
REQ-022 Arithmetic SHALL be WIDTH bits modulo MODULUS; count SHALL never take a value >= MODULUS.
REQ-023 Direction change mid-sequence SHALL take effect on the next enabled edge, with no extra latency.
REQ-024 When MODULUS==2**WIDTH, behaviour SHALL equal natural binary wrap.

Reset
REQ-025 rst_n=0 SHALL immediately force count=0 and ovf=0, independent of clk.
REQ-026 Assertion of rst_n mid-count SHALL discard the operation in progress; tc SHALL follow its combinational definition during reset (count=0).
REQ-027 After rst_n deasserts, the first state change SHALL occur on the first rising clk edge with rst_n=1.

Configuration
REQ-028 Macro COUNTER_SATURATE_EN selects terminal behaviour.
REQ-029 Without COUNTER_SATURATE_EN: wrap per REQ-016/REQ-017.
REQ-030 With COUNTER_SATURATE_EN: at terminal count (tc=1), count SHALL hold (MODULUS-1 when up, 0 when down) instead of wrapping; tc and ovf SHALL behave identically to the non-saturating build.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-031 rst_n=0 mid-count at count=7 -> count=0, ovf=0 immediately, before the next clk edge.
REQ-032 en=1, up_dn=1 from 0 for 10 edges -> count 1..9,0; tc=1 only while count=9; ovf=1 from the 10th edge.
REQ-033 en=1, up_dn=0 from 0 -> tc=1 at count=0, next count=9, ovf=1; then load=1, load_val=12 -> count=9, ovf=0.
REQ-034 clr=1, load=1, en=1 in the same cycle at count=5 -> count=0, ovf=0, tc=0.
REQ-035 Two instances cascaded (tc of the low instance drives en of the high instance), en=1 for 25 edges -> high=2, low=5.
REQ-036 COUNTER_SATURATE_EN defined, up from 8 for 3 edges -> count 9,9,9; tc=1 while at 9; ovf=1.
